vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Shares one single-port board RAM between the VGA display scan and the Tetris game logic. Fixed display fetch slots are derived from the VGA timing generator's pixel and line counters. Game-side reads and writes are scheduled into all remaining cycles. The block also produces the per-pixel board colour for the video output stage.

## Interface
Parameters:
- CELL_SHIFT, 4: log2 of cell size in pixels (16×16 cells).
- BOARD_W, 10: board width in cells.
- BOARD_H, 20: board height in cells.
- ORG_X, 160: first board pixel column. Must be ≥ 2.
- ORG_Y, 80: first board pixel line.
- AW, 8: RAM address width. Must satisfy 2^AW ≥ BOARD_W·BOARD_H.
- DW, 4: colour / RAM data width.
- BG_COLOR, 0: colour output outside the board.

Ports:
- PCLK_I, in, 1: pixel clock. Only clock.
- RST_N_I, in, 1: reset. Synchronous, active-low.
- HCNT_I, in, 11: pixel counter from the timing generator.
- VCNT_I, in, 11: line counter from the timing generator.
- BLANK_I, in, 1: 1 = active video (data enable).
- GREQ_I, in, 1: game request. Held until GACK_O.
- GWE_I, in, 1: 1 = write, 0 = read. Stable while GREQ_I is high.
- GADDR_I, in, AW: game cell address. Stable while GREQ_I is high.
- GWDATA_I, in, DW: game write data. Stable while GREQ_I is high.
- GACK_O, out, 1: one-cycle completion pulse.
- GRDATA_O, out, DW: read data. Valid with GACK_O and held until the next read ack.
- RAM_ADDR_O, out, AW: RAM address (combinational from arbiter state).
- RAM_WE_O, out, 1: RAM write enable.
- RAM_WDATA_O, out, DW: RAM write data.
- RAM_RDATA_I, in, DW: RAM read data. The RAM is synchronous with 1-cycle read latency.
- PIXEL_O, out, DW: registered pixel colour.
- PIXEL_VALID_O, out, 1: registered copy of BLANK_I.

## Operation
- Board region: ORG_X ≤ HCNT_I < ORG_X+BOARD_W·2^CELL_SHIFT and ORG_Y ≤ VCNT_I < ORG_Y+BOARD_H·2^CELL_SHIFT.
- Display slot: a cycle in which VCNT_I is inside the board rows and HCNT_I == ORG_X − 2 + k·2^CELL_SHIFT, for k = 0..BOARD_W−1.
  - Slots depend only on the counters, not on BLANK_I.
  - In a slot: RAM_ADDR_O = row·BOARD_W + k, where row = (VCNT_I − ORG_Y) >> CELL_SHIFT. RAM_WE_O = 0.
  - On the edge ending the cycle after the slot, RAM_RDATA_I is captured into the cell register.
- PIXEL_O is updated on every edge: the cell register if the current HCNT_I/VCNT_I is inside the board and BLANK_I = 1, otherwise BG_COLOR.
- Game FSM has two states: IDLE and RESP.
  - IDLE → RESP when GREQ_I = 1 and the cycle is not a display slot. In that cycle: RAM_ADDR_O = GADDR_I, RAM_WE_O = GWE_I, RAM_WDATA_O = GWDATA_I.
  - In a display slot, IDLE stays IDLE; the game request is deferred by exactly 1 cycle.
  - RESP → IDLE unconditionally. GACK_O = 1 in RESP. For a read, GRDATA_O is loaded from RAM_RDATA_I on the RESP edge.
  - GREQ_I is ignored in RESP, so at most one game operation completes per 2 cycles.
- Out-of-range address (GADDR_I ≥ BOARD_W·BOARD_H):
  - RAM_WE_O is forced to 0.
  - A read returns GRDATA_O = 0.
  - GACK_O is still issued.
- When no access is scheduled, RAM_WE_O = 0 and RAM_ADDR_O = 0.

## Timing
- Reset (RST_N_I low at an edge):
  - FSM goes to IDLE; GACK_O = 0; GRDATA_O = 0.
  - PIXEL_O = 0; PIXEL_VALID_O = 0; cell register = 0.
  - RAM_WE_O is held at 0 while RST_N_I is low.
- Reset mid-operation drops the outstanding request with no GACK_O. The requester re-presents it after reset.
- Game latency: GACK_O one cycle after issue. Minimum 1 cycle after GREQ_I is sampled; maximum 2 cycles (display collision).
- Display pipeline:
  - Slot at HCNT = X−2; RAM data during HCNT = X−1; cell register valid during HCNT = X..X+15.
  - PIXEL_O lags HCNT_I by 1 cycle. The downstream stage delays sync signals by 1 to match.
- Line/frame wrap needs no special handling: slots are recomputed from the counters every cycle.

## Test plan
Defaults apply: ORG_X=160, ORG_Y=80, 16-px cells, 10×20 board.
- Reset: hold RST_N_I = 0 for 2 cycles with GREQ_I = 1 and GWE_I = 1 → GACK_O = 0, RAM_WE_O = 0, PIXEL_O = 0, PIXEL_VALID_O = 0 throughout.
- Write at HCNT = 0: GADDR_I = 13, GWDATA_I = 0xA → in the same cycle RAM_WE_O = 1, RAM_ADDR_O = 13, RAM_WDATA_O = 0xA; GACK_O = 1 on the next cycle only.
- Display fetch: RAM[11] = 0x5, VCNT = 96, BLANK = 1, HCNT sweeping →
  - at HCNT = 174: RAM_ADDR_O = 11, RAM_WE_O = 0;
  - PIXEL_O = 0x5 in the cycles after HCNT 176..191.
- Collision: a read of address 13 is asserted in the cycle HCNT = 158, VCNT = 80 →
  - at 158: RAM_ADDR_O = 0 (display);
  - at 159: RAM_ADDR_O = 13;
  - at 160: GACK_O = 1 with GRDATA_O = 0xA.
- Out of range: write to address 200 → RAM_WE_O stays 0 and GACK_O pulses. Read of address 255 → GRDATA_O = 0.
- Edges: HCNT = 320 or VCNT = 400 → PIXEL_O = BG_COLOR on the following cycle. At VCNT = 400 no display slots occur; RAM_ADDR_O = 0 and RAM_WE_O = 0 whenever no game request is pending.

Source files
------------

// File: rtl/vram_arbiter.sv
// Board RAM arbiter: fixed display fetch slots from the VGA counters, game
// reads/writes in all other cycles, plus the registered per-pixel board colour.
module vram_arbiter #(
    parameter int unsigned CELL_SHIFT = 4,
    parameter int unsigned BOARD_W    = 10,
    parameter int unsigned BOARD_H    = 20,
    parameter int unsigned ORG_X      = 160,
    parameter int unsigned ORG_Y      = 80,
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 4,
    parameter int unsigned BG_COLOR   = 0
) (
    input  logic          PCLK_I,
    input  logic          RST_N_I,
    input  logic [10:0]   HCNT_I,
    input  logic [10:0]   VCNT_I,
    input  logic          BLANK_I,
    input  logic          GREQ_I,
    input  logic          GWE_I,
    input  logic [AW-1:0] GADDR_I,
    input  logic [DW-1:0] GWDATA_I,
    output logic          GACK_O,
    output logic [DW-1:0] GRDATA_O,
    output logic [AW-1:0] RAM_ADDR_O,
    output logic          RAM_WE_O,
    output logic [DW-1:0] RAM_WDATA_O,
    input  logic [DW-1:0] RAM_RDATA_I,
    output logic [DW-1:0] PIXEL_O,
    output logic          PIXEL_VALID_O
);

    localparam int unsigned CELL_PX = 1 << CELL_SHIFT;
    localparam int unsigned CELLS   = BOARD_W * BOARD_H;
    localparam logic [10:0] X0      = 11'(ORG_X);
    localparam logic [10:0] X1      = 11'(ORG_X + BOARD_W * CELL_PX);
    localparam logic [10:0] Y0      = 11'(ORG_Y);
    localparam logic [10:0] Y1      = 11'(ORG_Y + BOARD_H * CELL_PX);
    // Fetch two pixels early: one cycle for the RAM, one to land in the cell register.
    localparam logic [10:0] SX0     = 11'(ORG_X - 2);
    localparam logic [DW-1:0] BG    = DW'(BG_COLOR);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t        r_state;
    logic          r_gack;
    logic          r_rd;
    logic          r_rd_oor;
    logic [DW-1:0] r_grdata;
    logic          r_fetch;
    logic [DW-1:0] r_cell;
    logic [DW-1:0] r_pixel;
    logic          r_pix_valid;

    logic          w_in_rows;
    logic          w_in_cols;
    logic [10:0]   w_hoff;
    logic [10:0]   w_k;
    logic          w_slot;
    logic [AW-1:0] w_vrow;
    logic [AW-1:0] w_disp_addr;
    logic          w_oor;
    logic          w_issue;
    logic [DW-1:0] w_resp_data;

    // Board geometry and display slot decode from the timing counters.
    assign w_in_rows   = (VCNT_I >= Y0) && (VCNT_I < Y1);
    assign w_in_cols   = (HCNT_I >= X0) && (HCNT_I < X1);
    assign w_hoff      = HCNT_I - SX0;
    assign w_k         = w_hoff >> CELL_SHIFT;
    assign w_slot      = w_in_rows && (HCNT_I >= SX0)
                         && (w_hoff[CELL_SHIFT-1:0] == '0)
                         && (w_k < 11'(BOARD_W));
    assign w_vrow      = AW'((VCNT_I - Y0) >> CELL_SHIFT);
    assign w_disp_addr = w_vrow * AW'(BOARD_W) + AW'(w_k);

    // Game request decode: issue only from IDLE outside display slots.
    assign w_oor       = 32'(GADDR_I) >= CELLS;
    assign w_issue     = RST_N_I && (r_state == S_IDLE) && GREQ_I && !w_slot;
    assign w_resp_data = r_rd_oor ? '0 : RAM_RDATA_I;

    // RAM port mux: display slot has priority, then an issuing game access.
    always_comb begin
        RAM_ADDR_O  = '0;
        RAM_WE_O    = 1'b0;
        RAM_WDATA_O = '0;
        if (RST_N_I) begin
            if (w_slot) begin
                RAM_ADDR_O = w_disp_addr;
            end else if (w_issue) begin
                RAM_ADDR_O  = GADDR_I;
                RAM_WE_O    = GWE_I && !w_oor;
                RAM_WDATA_O = GWDATA_I;
            end
        end
    end

    // Game FSM: IDLE issues, RESP acknowledges and captures read data.
    always_ff @(posedge PCLK_I) begin
        if (!RST_N_I) begin
            r_state  <= S_IDLE;
            r_gack   <= 1'b0;
            r_rd     <= 1'b0;
            r_rd_oor <= 1'b0;
            r_grdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state  <= S_RESP;
                        r_gack   <= 1'b1;
                        r_rd     <= !GWE_I;
                        r_rd_oor <= w_oor;
                    end else begin
                        r_gack   <= 1'b0;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_gack  <= 1'b0;
                    if (r_rd) begin
                        r_grdata <= w_resp_data;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gack  <= 1'b0;
                end
            endcase
        end
    end

    // Display pipeline: capture fetched cell colour, then register pixel colour.
    always_ff @(posedge PCLK_I) begin
        if (!RST_N_I) begin
            r_fetch     <= 1'b0;
            r_cell      <= '0;
            r_pixel     <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_fetch <= w_slot;
            if (r_fetch) begin
                r_cell <= RAM_RDATA_I;
            end
            r_pixel     <= (w_in_rows && w_in_cols && BLANK_I) ? r_cell : BG;
            r_pix_valid <= BLANK_I;
        end
    end

    // Read data is presented alongside the ack and held in r_grdata afterwards.
    assign GACK_O        = r_gack;
    assign GRDATA_O      = (r_gack && r_rd) ? w_resp_data : r_grdata;
    assign PIXEL_O       = r_pixel;
    assign PIXEL_VALID_O = r_pix_valid;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: behavioural RAM plus a cell-level
// reference model of board contents, slot positions and game latency.
module tb_vram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [10:0] hcnt, vcnt;
    logic       blank;
    logic       greq, gwe;
    logic [7:0] gaddr;
    logic [3:0] gwdata;
    logic       gack;
    logic [3:0] grdata;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [3:0] ram_wdata;
    logic [3:0] ram_rdata;
    logic [3:0] pixel;
    logic       pixel_valid;

    int tests = 0;
    int fails = 0;
    int last_rd = 0;
    int ref_mem [200];
    logic [3:0] mem [256];

    always #5 clk = ~clk;

    vram_arbiter dut (
        .PCLK_I(clk), .RST_N_I(rst_n), .HCNT_I(hcnt), .VCNT_I(vcnt),
        .BLANK_I(blank), .GREQ_I(greq), .GWE_I(gwe), .GADDR_I(gaddr),
        .GWDATA_I(gwdata), .GACK_O(gack), .GRDATA_O(grdata),
        .RAM_ADDR_O(ram_addr), .RAM_WE_O(ram_we), .RAM_WDATA_O(ram_wdata),
        .RAM_RDATA_I(ram_rdata), .PIXEL_O(pixel), .PIXEL_VALID_O(pixel_valid)
    );

    // Synchronous single-port RAM, 1-cycle read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rows(input int v);
        return v >= 80 && v < 80 + 20 * 16;
    endfunction

    function automatic bit in_board(input int h, input int v);
        return in_rows(v) && h >= 160 && h < 160 + 10 * 16;
    endfunction

    // A slot is two pixels before the left edge of each board cell.
    function automatic bit is_slot(input int h, input int v);
        int x;
        x = h + 2 - 160;
        return in_rows(v) && x >= 0 && x < 160 && (x % 16) == 0;
    endfunction

    function automatic int slot_addr(input int h, input int v);
        return ((v - 80) / 16) * 10 + (h + 2 - 160) / 16;
    endfunction

    function automatic int exp_pixel(input int h, input int v, input bit b);
        if (in_board(h, v) && b) return ref_mem[((v - 80) / 16) * 10 + (h - 160) / 16];
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one line of counters with no game traffic; check slots and pixels.
    task automatic sweep(input int v, input int h0, input int h1, input int bmode);
        bit b;
        for (int h = h0; h <= h1; h++) begin
            b = (bmode == 2) ? 1'($urandom % 2) : 1'(bmode);
            hcnt = 11'(h); vcnt = 11'(v); blank = b;
            #1;
            if (is_slot(h, v)) chk("slot_addr", ram_addr, slot_addr(h, v));
            else               chk("idle_addr", ram_addr, 0);
            chk("sweep_we", ram_we, 0);
            tick();
            chk("pixel", pixel, exp_pixel(h, v, b));
            chk("pixel_valid", pixel_valid, b);
        end
    endtask

    // One game operation starting at the given counter position.
    task automatic op(input bit we, input int addr, input int data, input int h0, input int v0);
        int  h;
        int  waitc;
        bit  oor;
        int  exp_rd;
        h = h0; waitc = 0;
        oor = addr >= 200;
        exp_rd = oor ? 0 : ref_mem[addr];
        greq = 1'b1; gwe = we; gaddr = 8'(addr); gwdata = 4'(data);
        hcnt = 11'(h); vcnt = 11'(v0); blank = 1'b0;
        #1;
        while (is_slot(h, v0) && waitc < 2) begin
            chk("defer_addr", ram_addr, slot_addr(h, v0));
            chk("defer_we", ram_we, 0);
            waitc++;
            tick();
            h++; hcnt = 11'(h);
            #1;
            chk("defer_noack", gack, 0);
        end
        chk("latency_bound", waitc <= 1, 1);
        chk("issue_addr", ram_addr, addr);
        chk("issue_we", ram_we, (we && !oor) ? 1 : 0);
        if (we) chk("issue_wdata", ram_wdata, data);
        tick();
        h++; hcnt = 11'(h);
        chk("ack", gack, 1);
        if (!we) begin
            chk("rdata", grdata, exp_rd);
            last_rd = exp_rd;
        end
        greq = 1'b0;
        if (we && !oor) ref_mem[addr] = data;
        tick();
        h++; hcnt = 11'(h);
        chk("ack_pulse", gack, 0);
        chk("rdata_held", grdata, last_rd);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 4'h0;
        mem[255] = 4'hF;
        mem[200] = 4'h3;
        for (int i = 0; i < 200; i++) ref_mem[i] = 0;

        // Reset with a pending write request.
        rst_n = 1'b0; greq = 1'b1; gwe = 1'b1; gaddr = 8'd13; gwdata = 4'h5;
        hcnt = '0; vcnt = '0; blank = 1'b1;
        #1;
        chk("rst_we_comb", ram_we, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_gack", gack, 0);
            chk("rst_we", ram_we, 0);
            chk("rst_pixel", pixel, 0);
            chk("rst_valid", pixel_valid, 0);
            chk("rst_grdata", grdata, 0);
        end
        greq = 1'b0; blank = 1'b0;
        rst_n = 1'b1;
        tick();

        // Basic write and collision read.
        op(1'b1, 13, 'hA, 0, 0);
        op(1'b0, 13, 0, 158, 80);

        // Reset in the issue cycle drops the operation with no ack.
        greq = 1'b1; gwe = 1'b1; gaddr = 8'd50; gwdata = 4'h7; hcnt = '0; vcnt = '0;
        #1;
        chk("pre_rst_we", ram_we, 1);
        rst_n = 1'b0;
        tick();
        chk("midrst_gack", gack, 0);
        greq = 1'b0; rst_n = 1'b1;
        last_rd = 0;
        tick();
        chk("midrst_gack2", gack, 0);
        op(1'b0, 50, 0, 5, 5);

        // Display fetch on row 1.
        op(1'b1, 11, 'h5, 0, 0);
        op(1'b1, 17, 'hC, 3, 10);
        sweep(96, 0, 340, 1);

        // Out-of-range accesses.
        op(1'b1, 200, 'h9, 20, 20);
        op(1'b0, 255, 0, 40, 20);
        op(1'b0, 200, 0, 174, 96);

        // Randomised game traffic, with forced slot collisions.
        for (int n = 0; n < 40; n++) begin
            bit we;
            int a, h0, v0;
            we = 1'($urandom % 2);
            a  = ($urandom % 8 == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 199));
            if ($urandom % 3 == 0) begin
                h0 = 158 + 16 * int'($urandom_range(0, 9));
                v0 = int'($urandom_range(80, 399));
            end else begin
                h0 = int'($urandom_range(0, 799));
                v0 = int'($urandom_range(0, 524));
            end
            op(we, a, int'($urandom % 16), h0, v0);
        end

        // Post-traffic display checks, including bottom-edge and random blanking.
        sweep(80, 0, 330, 1);
        sweep(int'($urandom_range(100, 399)), 0, 330, 2);
        sweep(399, 0, 330, 1);
        sweep(400, 0, 330, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound in case the run stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
